// File: rtl/turf_bus_master_v3.sv
// TURFIO-side master for the TURF parallel register bus: turns local read/write strobes into
// a chip-select framed, IOB-registered burst. Optional per-beat odd parity via TURF_BUS_PARITY_EN.
module turf_bus_master_v3 #(
  parameter int BUS_WIDTH  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TURNAROUND = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  busy_o,
  inout  wire  [BUS_WIDTH-1:0]  TURF_DIO,
  output logic                  TURF_WnR,
  output logic                  nCSTURF
`ifdef TURF_BUS_PARITY_EN
  ,
  inout  wire                   TURF_PAR
`endif
);

  // state  | meaning
  // IDLE   | bus idle, strobes accepted
  // ADDR   | address beat being launched to the pads
  // WR     | write data beats, beat_q selects the slice
  // TA     | read turnaround plus pad out/in round trip
  // RD     | read beats arriving from the input IOB register
  // DONE   | ack_o pulse, read word / parity flag valid

  localparam int BEATS  = DATA_WIDTH / BUS_WIDTH;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TA_LEN = TURNAROUND + 2;
  localparam int TA_W   = 4;

  if (BEATS * BUS_WIDTH != DATA_WIDTH) begin : g_chk_mult
    $error("DATA_WIDTH must be an integer multiple of BUS_WIDTH");
  end
  if (BEATS < 1 || BEATS > 16) begin : g_chk_beats
    $error("BEATS must be in 1..16");
  end
  if (ADDR_WIDTH > BUS_WIDTH) begin : g_chk_addr
    $error("ADDR_WIDTH must not exceed BUS_WIDTH");
  end
  if (TURNAROUND < 0 || TURNAROUND > 7) begin : g_chk_ta
    $error("TURNAROUND must be in 0..7");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WR   = 3'd2,
    S_TA   = 3'd3,
    S_RD   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        beat_q;
  logic [TA_W-1:0]         ta_q;
  logic                    is_rd_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    accept;
  logic                    beat_last;
  logic                    ta_done;

  logic                    cs_d;
  logic                    wnr_d;
  logic                    oe_d;
  logic [BUS_WIDTH-1:0]    dout_d;
  logic [BUS_WIDTH-1:0]    wslice;

  // pad-side IOB registers, deliberately without reset so they pack into the IOBs
  logic                    cs_q;
  logic                    wnr_q;
  logic [BUS_WIDTH-1:0]    oe_q;
  logic [BUS_WIDTH-1:0]    dout_q;
  logic [BUS_WIDTH-1:0]    din_q;

`ifdef TURF_BUS_PARITY_EN
  logic                    par_err_q;
  logic                    par_oe_q;
  logic                    par_out_q;
  logic                    par_in_q;
`endif

  assign accept    = (rd_i | wr_i) && (state_q == S_IDLE);
  assign beat_last = (beat_q == CNT_W'(BEATS - 1));
  assign ta_done   = (ta_q == '0);

  // state register, transaction latches, counters and read assembly
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      ta_q    <= '0;
      is_rd_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef TURF_BUS_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_rd_q <= rd_i;
        addr_q  <= addr_i;
        wdata_q <= dat_i;
      end
      case (state_q)
        S_ADDR: begin
          beat_q <= '0;
          ta_q   <= TA_W'(TA_LEN - 1);
        end
        S_TA: begin
          beat_q <= '0;
          if (!ta_done) ta_q <= ta_q - 1'b1;
        end
        S_WR: begin
          beat_q <= beat_last ? '0 : beat_q + 1'b1;
        end
        S_RD: begin
          beat_q <= beat_last ? '0 : beat_q + 1'b1;
          for (int k = 0; k < BEATS; k++) begin
            if (beat_q == CNT_W'(k)) rdata_q[k*BUS_WIDTH +: BUS_WIDTH] <= din_q;
          end
        end
        default: begin
          beat_q <= '0;
        end
      endcase
`ifdef TURF_BUS_PARITY_EN
      // sticky across the burst; odd parity means beat ^ par must be 1
      if (accept) begin
        par_err_q <= 1'b0;
      end else if (state_q == S_RD && !((^din_q) ^ par_in_q)) begin
        par_err_q <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_ADDR;
      S_ADDR: state_d = is_rd_q ? S_TA : S_WR;
      S_WR:   if (beat_last) state_d = S_DONE;
      S_TA:   if (ta_done) state_d = S_RD;
      S_RD:   if (beat_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
    ack_o  = (state_q == S_DONE);
    dat_o  = rdata_q;
`ifdef TURF_BUS_PARITY_EN
    err_o  = ack_o & par_err_q;
`else
    err_o  = 1'b0;
`endif

    wslice = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_q == CNT_W'(k)) wslice = wdata_q[k*BUS_WIDTH +: BUS_WIDTH];
    end

    // chip select releases while the last read beat is still in the input register
    cs_d = !((state_q == S_ADDR) || (state_q == S_WR) || (state_q == S_TA) ||
             ((state_q == S_RD) && !beat_last));
    wnr_d  = cs_d ? 1'b1 : !is_rd_q;
    oe_d   = (state_q == S_ADDR) || (state_q == S_WR);
    dout_d = (state_q == S_ADDR) ? BUS_WIDTH'(addr_q) : wslice;
  end

  always_ff @(posedge clk_i) begin
    cs_q   <= cs_d;
    wnr_q  <= wnr_d;
    oe_q   <= {BUS_WIDTH{oe_d}};
    dout_q <= dout_d;
    din_q  <= TURF_DIO;
`ifdef TURF_BUS_PARITY_EN
    par_oe_q  <= oe_d;
    par_out_q <= ~^dout_d;
    par_in_q  <= TURF_PAR;
`endif
  end

  assign nCSTURF  = cs_q;
  assign TURF_WnR = wnr_q;

  for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_dio
    assign TURF_DIO[i] = oe_q[i] ? dout_q[i] : 1'bz;
  end

`ifdef TURF_BUS_PARITY_EN
  assign TURF_PAR = par_oe_q ? par_out_q : 1'bz;
`endif

endmodule
